// File: rtl/ps2_scancode_decoder_if.sv
// Key-event stream from the PS/2 scan-code decoder to its consumer.
// The producer drives valid/payload; the consumer drives ready.
interface ps2_scancode_decoder_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic [7:0] evt_ascii;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_ext,
        output evt_break,
        output evt_ascii,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_ext,
        input  evt_break,
        input  evt_ascii,
        output evt_ready
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code-set-2 decoder: prefix FSM, shift/caps tracking, FWFT event FIFO.
// Optional macro PS2_ASCII_MAP_EN adds an ASCII lookup stored with each event.
module ps2_scancode_decoder #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic                          clk_50,
    input  logic                          rst,
    input  logic [7:0]                    sc_in,
    input  logic                          got_code,
    ps2_scancode_decoder_if.master        evt,
    output logic                          shift_held,
    output logic                          caps_lock,
    output logic                          overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_ASCII_MAP_EN
    localparam int EW = 18;
`else
    localparam int EW = 10;
`endif

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_EXT     = 3'd1;
    localparam logic [2:0] ST_BRK     = 3'd2;
    localparam logic [2:0] ST_EXT_BRK = 3'd3;
    localparam logic [2:0] ST_PAUSE   = 3'd4;

    logic          sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic          strobe_q, strobe_d;
    logic [7:0]    byte_q, byte_d;
    logic [2:0]    state_q, state_d;
    logic [2:0]    pause_q, pause_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          lshift_q, lshift_d, rshift_q, rshift_d;
    logic          caps_q, caps_d, caps_down_q, caps_down_d;
    logic          overflow_q, overflow_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [EW-1:0] fifo_mem [DEPTH];

    logic          push, push_ext, push_brk, pop, full, wr_en;
    logic [7:0]    push_code;
    logic [EW-1:0] push_entry, head;

`ifdef PS2_ASCII_MAP_EN
    function automatic logic [7:0] ascii_lookup(input logic [7:0] code,
                                                input logic shift,
                                                input logic caps);
        logic [7:0] letter;
        logic [7:0] result;
        letter = 8'h00;
        result = 8'h00;
        case (code)
            8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63;
            8'h23: letter = 8'h64; 8'h24: letter = 8'h65; 8'h2B: letter = 8'h66;
            8'h34: letter = 8'h67; 8'h33: letter = 8'h68; 8'h43: letter = 8'h69;
            8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
            8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F;
            8'h4D: letter = 8'h70; 8'h15: letter = 8'h71; 8'h2D: letter = 8'h72;
            8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74; 8'h3C: letter = 8'h75;
            8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
            8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
            default: letter = 8'h00;
        endcase
        if (letter != 8'h00) begin
            result = (shift ^ caps) ? (letter - 8'h20) : letter;
        end else begin
            case (code)
                8'h16: result = shift ? 8'h21 : 8'h31;
                8'h1E: result = shift ? 8'h40 : 8'h32;
                8'h26: result = shift ? 8'h23 : 8'h33;
                8'h25: result = shift ? 8'h24 : 8'h34;
                8'h2E: result = shift ? 8'h25 : 8'h35;
                8'h36: result = shift ? 8'h5E : 8'h36;
                8'h3D: result = shift ? 8'h26 : 8'h37;
                8'h3E: result = shift ? 8'h2A : 8'h38;
                8'h46: result = shift ? 8'h28 : 8'h39;
                8'h45: result = shift ? 8'h29 : 8'h30;
                8'h29: result = 8'h20;
                8'h5A: result = 8'h0D;
                8'h66: result = 8'h08;
                default: result = 8'h00;
            endcase
        end
        return result;
    endfunction
`endif

    // got_code is asynchronous; its synchronised falling edge marks a new byte.
    always_comb begin
        sync1_d  = got_code;
        sync2_d  = sync1_q;
        sync3_d  = sync2_q;
        strobe_d = sync3_q & ~sync2_q;
        byte_d   = strobe_d ? sc_in : byte_q;
    end

    always_comb begin
        state_d   = state_q;
        pause_d   = pause_q;
        tmo_d     = tmo_q;
        push      = 1'b0;
        push_code = byte_q;
        push_ext  = 1'b0;
        push_brk  = 1'b0;
        if (strobe_q) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    case (byte_q)
                        8'hE0: state_d = ST_EXT;
                        8'hF0: state_d = ST_BRK;
                        8'hE1: begin
                            state_d = ST_PAUSE;
                            pause_d = 3'd7;
                        end
                        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: state_d = ST_IDLE;
                        default: push = 1'b1;
                    endcase
                end
                ST_EXT: begin
                    if (byte_q == 8'hF0) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        state_d  = ST_IDLE;
                        push     = (byte_q != 8'h12) && (byte_q != 8'h59);
                        push_ext = 1'b1;
                    end
                end
                ST_BRK: begin
                    state_d  = ST_IDLE;
                    push     = 1'b1;
                    push_brk = 1'b1;
                end
                ST_EXT_BRK: begin
                    state_d  = ST_IDLE;
                    push     = (byte_q != 8'h12) && (byte_q != 8'h59);
                    push_ext = 1'b1;
                    push_brk = 1'b1;
                end
                ST_PAUSE: begin
                    pause_d = pause_q - 3'd1;
                    if (pause_q == 3'd1) begin
                        state_d   = ST_IDLE;
                        push      = 1'b1;
                        push_code = 8'hE1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            // A stalled prefix is abandoned so a lost byte cannot corrupt later keys.
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    // Caps toggles only on the first make after a release, so typematic repeats are inert.
    always_comb begin
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        caps_d      = caps_q;
        caps_down_d = caps_down_q;
        if (push && !push_ext) begin
            case (push_code)
                8'h12: lshift_d = ~push_brk;
                8'h59: rshift_d = ~push_brk;
                8'h58: begin
                    if (push_brk) begin
                        caps_down_d = 1'b0;
                    end else begin
                        if (!caps_down_q) caps_d = ~caps_q;
                        caps_down_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PS2_ASCII_MAP_EN
    assign push_entry = {(push_brk || push_ext) ? 8'h00
                         : ascii_lookup(push_code, lshift_q | rshift_q, caps_q),
                         push_brk, push_ext, push_code};
`else
    assign push_entry = {push_brk, push_ext, push_code};
`endif

    always_comb begin
        pop        = (count_q != '0) && evt.evt_ready;
        full       = (count_q == CW'(DEPTH));
        wr_en      = push && (!full || pop);
        wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(wr_en) - CW'(pop);
        overflow_d = overflow_q | (push && full && !pop);
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            strobe_q    <= 1'b0;
            byte_q      <= 8'h00;
            state_q     <= ST_IDLE;
            pause_q     <= 3'd0;
            tmo_q       <= '0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_q      <= 1'b0;
            caps_down_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            strobe_q    <= strobe_d;
            byte_q      <= byte_d;
            state_q     <= state_d;
            pause_q     <= pause_d;
            tmo_q       <= tmo_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            caps_q      <= caps_d;
            caps_down_q <= caps_down_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk_50) begin
        if (wr_en) fifo_mem[wr_ptr_q] <= push_entry;
    end

    // Payload is gated by valid so every output reads 0 while the FIFO is empty.
    assign head          = fifo_mem[rd_ptr_q];
    assign evt.evt_valid = (count_q != '0);
    assign evt.evt_code  = evt.evt_valid ? head[7:0] : 8'h00;
    assign evt.evt_ext   = evt.evt_valid & head[8];
    assign evt.evt_break = evt.evt_valid & head[9];
`ifdef PS2_ASCII_MAP_EN
    assign evt.evt_ascii = evt.evt_valid ? head[17:10] : 8'h00;
`else
    assign evt.evt_ascii = 8'h00;
`endif
    assign shift_held = lshift_q | rshift_q;
    assign caps_lock  = caps_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder; expected events are queued as bytes are sent.
`timescale 1ns/1ps
module tb_ps2_scancode_decoder;
    localparam int DEPTH = 8;
    localparam int TO    = 64;
`ifdef PS2_ASCII_MAP_EN
    localparam bit ASCII_EN = 1'b1;
`else
    localparam bit ASCII_EN = 1'b0;
`endif

    logic       clk_50 = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sc_in = 8'h00;
    logic       got_code = 1'b0;
    logic       shift_held, caps_lock, overflow;
    int         errors = 0;
    int         checks = 0;
    logic [17:0] sb [$];

    ps2_scancode_decoder_if evt_if ();

    ps2_scancode_decoder #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk_50    (clk_50),
        .rst       (rst),
        .sc_in     (sc_in),
        .got_code  (got_code),
        .evt       (evt_if),
        .shift_held(shift_held),
        .caps_lock (caps_lock),
        .overflow  (overflow)
    );

    always #5 clk_50 = ~clk_50;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic expectEvent(input logic [7:0] code, input logic ext,
                               input logic brk, input logic [7:0] ascii);
        sb.push_back({ASCII_EN ? ascii : 8'h00, brk, ext, code});
    endtask

    // One receiver frame: busy high for a few cycles, then idle long enough to decode.
    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk_50); #1;
        sc_in    = b;
        got_code = 1'b1;
        repeat (4) @(posedge clk_50);
        #1 got_code = 1'b0;
        repeat (8) @(posedge clk_50);
        #1;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk_50);
        #1;
        checkOutput("drain", sb.size(), 0);
    endtask

    // Consumer side: every accepted head is compared against the oldest expectation.
    always @(negedge clk_50) begin
        if (!rst && evt_if.evt_valid && evt_if.evt_ready) begin
            if (sb.size() == 0) begin
                checkOutput("sb_nonempty", sb.size(), 1);
            end else begin
                checkOutput("evt", {evt_if.evt_ascii, evt_if.evt_break, evt_if.evt_ext,
                                    evt_if.evt_code}, sb.pop_front());
            end
        end
    end

    initial begin
        evt_if.evt_ready = 1'b0;
        repeat (4) @(posedge clk_50);
        #1 rst = 1'b0;
        checkOutput("rst_valid", evt_if.evt_valid, 0);
        checkOutput("rst_shift", shift_held, 0);
        checkOutput("rst_caps", caps_lock, 0);
        checkOutput("rst_ovf", overflow, 0);

        // Latency of a single make.
        expectEvent(8'h1C, 0, 0, 8'h61);
        @(posedge clk_50); #1;
        sc_in = 8'h1C; got_code = 1'b1;
        repeat (4) @(posedge clk_50);
        #1 got_code = 1'b0;
        repeat (3) @(posedge clk_50);
        #1 checkOutput("lat_early", evt_if.evt_valid, 0);
        @(posedge clk_50);
        #1 checkOutput("lat_valid", evt_if.evt_valid, 1);
        evt_if.evt_ready = 1'b1;
        waitDrain();

        // Shifted letter.
        expectEvent(8'h12, 0, 0, 8'h00);
        expectEvent(8'h1C, 0, 0, 8'h41);
        expectEvent(8'h1C, 0, 1, 8'h00);
        expectEvent(8'h12, 0, 1, 8'h00);
        applyStimulus(8'h12);
        checkOutput("shift_on", shift_held, 1);
        applyStimulus(8'h1C);
        applyStimulus(8'hF0); applyStimulus(8'h1C);
        checkOutput("shift_still", shift_held, 1);
        applyStimulus(8'hF0); applyStimulus(8'h12);
        checkOutput("shift_off", shift_held, 0);
        waitDrain();

        // Extended break and fake-shift suppression.
        expectEvent(8'h75, 1, 1, 8'h00);
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
        expectEvent(8'h7C, 1, 0, 8'h00);
        applyStimulus(8'hE0); applyStimulus(8'h12);
        applyStimulus(8'hE0); applyStimulus(8'h7C);
        checkOutput("fake_shift", shift_held, 0);
        waitDrain();

        // Pause sequence collapses to one event.
        expectEvent(8'hE1, 0, 0, 8'h00);
        applyStimulus(8'hE1); applyStimulus(8'h14); applyStimulus(8'h77);
        applyStimulus(8'hE1); applyStimulus(8'hF0); applyStimulus(8'h14);
        applyStimulus(8'hF0); applyStimulus(8'h77);
        waitDrain();

        // Caps lock with typematic repeat, then its effect on letters and digits.
        expectEvent(8'h58, 0, 0, 8'h00);
        expectEvent(8'h58, 0, 0, 8'h00);
        expectEvent(8'h58, 0, 1, 8'h00);
        applyStimulus(8'h58); applyStimulus(8'h58);
        applyStimulus(8'hF0); applyStimulus(8'h58);
        checkOutput("caps_once", caps_lock, 1);
        expectEvent(8'h1C, 0, 0, 8'h41);
        expectEvent(8'h16, 0, 0, 8'h31);
        expectEvent(8'h12, 0, 0, 8'h00);
        expectEvent(8'h1C, 0, 0, 8'h61);
        expectEvent(8'h16, 0, 0, 8'h21);
        expectEvent(8'h12, 0, 1, 8'h00);
        applyStimulus(8'h1C); applyStimulus(8'h16);
        applyStimulus(8'h12); applyStimulus(8'h1C); applyStimulus(8'h16);
        applyStimulus(8'hF0); applyStimulus(8'h12);
        waitDrain();

        // Overflow: DEPTH+1 makes with the consumer stalled.
        evt_if.evt_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) expectEvent(8'h01 + 8'(i), 0, 0, 8'h00);
            applyStimulus(8'h01 + 8'(i));
        end
        checkOutput("ovf_set", overflow, 1);
        checkOutput("ovf_valid", evt_if.evt_valid, 1);
        evt_if.evt_ready = 1'b1;
        waitDrain();
        checkOutput("ovf_sticky", overflow, 1);
        checkOutput("ovf_empty", evt_if.evt_valid, 0);

        // Stalled E0 prefix times out; the following byte is a plain make.
        expectEvent(8'h1C, 0, 0, 8'h41);
        applyStimulus(8'hE0);
        repeat (TO + 10) @(posedge clk_50);
        applyStimulus(8'h1C);
        waitDrain();

        // Reset mid-prefix discards the queued event and the partial sequence.
        evt_if.evt_ready = 1'b0;
        applyStimulus(8'h1C);
        applyStimulus(8'hF0);
        @(posedge clk_50); #1 rst = 1'b1;
        repeat (2) @(posedge clk_50);
        #1 rst = 1'b0;
        checkOutput("rst2_valid", evt_if.evt_valid, 0);
        checkOutput("rst2_ovf", overflow, 0);
        checkOutput("rst2_caps", caps_lock, 0);
        evt_if.evt_ready = 1'b1;
        expectEvent(8'h1C, 0, 0, 8'h61);
        applyStimulus(8'h1C);
        waitDrain();

        repeat (5) @(posedge clk_50);
        #1 checkOutput("final_empty", evt_if.evt_valid, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
